// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: hold codes, redirect causes,
// FSM states and the hold-pattern modes consumed by hold_pattern_gen.
package pipe_hazard_ctrl_pkg;

  localparam int HOLD_W  = 2;
  localparam int CAUSE_W = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [HOLD_W-1:0] {
    HOLD_NO    = 2'b00,
    HOLD_WAIT  = 2'b01,
    HOLD_FLUSH = 2'b10
  } hold_e;

  typedef enum logic [CAUSE_W-1:0] {
    JUMP_NO                 = 3'd0,
    JUMP_PREDICT_YES_BUT_NO = 3'd1,
    JUMP_PREDICT_NO_BUT_YES = 3'd2,
    JUMP_NOCONDITION        = 3'd3,
    JUMP_IRQ                = 3'd4,
    JUMP_RESUME             = 3'd5
  } jump_cause_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_IRQ_JMP = 3'd2,
    ST_HALTED  = 3'd3,
    ST_RESUME  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    MODE_NONE     = 3'd0,
    MODE_ALL_WAIT = 3'd1,
    MODE_MULTI    = 3'd2,
    MODE_REDIRECT = 3'd3,
    MODE_HALTED   = 3'd4
  } hold_mode_e;

  typedef enum logic {
    KIND_IRQ  = 1'b0,
    KIND_HALT = 1'b1
  } kind_e;

  // Only the three branch-type causes count as EX redirects; irq/resume codes are ours.
  function automatic logic is_ex_jump(input logic [CAUSE_W-1:0] cause);
    return (cause == JUMP_PREDICT_YES_BUT_NO) ||
           (cause == JUMP_PREDICT_NO_BUT_YES) ||
           (cause == JUMP_NOCONDITION);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hold_pattern_gen.sv
// Purely combinational map from a hold mode to the per-boundary hold vector.
// Boundary i occupies bits [2i+1:2i]; boundaries below EXS sit upstream of EX.
module hold_pattern_gen #(
  parameter int STAGES = 4,
  parameter int EXS    = STAGES - 1
) (
  input  logic [2:0]          mode,
  output logic [2*STAGES-1:0] hold
);
  import pipe_hazard_ctrl_pkg::*;

  always_comb begin
    hold = '0;
    for (int i = 0; i < STAGES; i++) begin
      case (hold_mode_e'(mode))
        MODE_ALL_WAIT: hold[2*i +: 2] = HOLD_WAIT;
        MODE_MULTI:    hold[2*i +: 2] = (i < EXS) ? HOLD_WAIT : HOLD_FLUSH;
        MODE_REDIRECT: begin
          if (i == 0)
            hold[2*i +: 2] = HOLD_WAIT;
          else if (i < EXS)
            hold[2*i +: 2] = HOLD_FLUSH;
          else
            hold[2*i +: 2] = HOLD_NO;
        end
        MODE_HALTED:   hold[2*i +: 2] = (i == 0) ? HOLD_WAIT : HOLD_NO;
        default:       hold[2*i +: 2] = HOLD_NO;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates stalls, EX redirects, interrupt entry and
// JTAG halt/resume, producing per-boundary hold codes and the PC redirect request.
module pipe_hazard_ctrl #(
  parameter int STAGES    = 4,
  parameter int EXS       = STAGES - 1,
  parameter int ADDR_W    = 32,
  parameter int DRAIN_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_wb_wr_wait_req_i,
  input  logic                ex_multi_clock_wait_req_i,
  input  logic [2:0]          ex_jump_cause_i,
  input  logic [ADDR_W-1:0]   ex_jump_from_addr_i,
  input  logic [ADDR_W-1:0]   ex_jump_to_addr_i,
  input  logic [ADDR_W-1:0]   epc_i,
  input  logic                irq_req_i,
  input  logic [ADDR_W-1:0]   irq_vector_i,
  input  logic                jtag_halt_req_i,
  output logic [2*STAGES-1:0] hold_ctrl_o,
  output logic [2:0]          jump_cause_o,
  output logic [ADDR_W-1:0]   jump_from_addr_o,
  output logic [ADDR_W-1:0]   jump_to_addr_o,
  output logic                irq_ack_o,
  output logic [ADDR_W-1:0]   irq_epc_o,
  output logic                jtag_halted_o
);
  import pipe_hazard_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC);

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  hold_mode_e        mode_sel;
  logic              ex_jump;
  logic              stall;

  assign ex_jump = is_ex_jump(ex_jump_cause_i);
  assign stall   = mem_wb_wr_wait_req_i | ex_multi_clock_wait_req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_IRQ;
      cnt_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

  // Any wait freezes the whole FSM, including the drain counter and captured EPC.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (!ex_jump && (irq_req_i || jtag_halt_req_i)) begin
            state_d = ST_DRAIN;
            kind_d  = irq_req_i ? KIND_IRQ : KIND_HALT;
            cnt_d   = DRAIN_LOAD;
            epc_d   = epc_i;
          end
        end
        ST_DRAIN: begin
          // A redirect retiring from EX moves the resume point to its target.
          if (ex_jump)
            epc_d = ex_jump_to_addr_i;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = (kind_q == KIND_IRQ) ? ST_IRQ_JMP : ST_HALTED;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_IRQ_JMP: state_d = ST_IDLE;
        ST_HALTED:  if (!jtag_halt_req_i) state_d = ST_RESUME;
        ST_RESUME:  state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mode_sel         = MODE_NONE;
    jump_cause_o     = JUMP_NO;
    jump_from_addr_o = '0;
    jump_to_addr_o   = '0;
    irq_ack_o        = 1'b0;
    irq_epc_o        = '0;
    jtag_halted_o    = (state_q == ST_HALTED);
    if (mem_wb_wr_wait_req_i) begin
      mode_sel = MODE_ALL_WAIT;
    end else if (ex_multi_clock_wait_req_i) begin
      mode_sel = MODE_MULTI;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_jump) begin
            mode_sel         = MODE_REDIRECT;
            jump_cause_o     = ex_jump_cause_i;
            jump_from_addr_o = ex_jump_from_addr_i;
            jump_to_addr_o   = ex_jump_to_addr_i;
          end
        end
        ST_DRAIN:  mode_sel = MODE_REDIRECT;
        ST_IRQ_JMP: begin
          jump_cause_o     = JUMP_IRQ;
          jump_from_addr_o = epc_q;
          jump_to_addr_o   = irq_vector_i;
          irq_ack_o        = 1'b1;
          irq_epc_o        = epc_q;
        end
        ST_HALTED: mode_sel = MODE_HALTED;
        ST_RESUME: begin
          jump_cause_o     = JUMP_RESUME;
          jump_from_addr_o = epc_q;
          jump_to_addr_o   = epc_q;
        end
        default:   mode_sel = MODE_NONE;
      endcase
    end
  end

  hold_pattern_gen #(
    .STAGES (STAGES),
    .EXS    (EXS)
  ) u_hold_pattern_gen (
    .mode (mode_sel),
    .hold (hold_ctrl_o)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  STAGES, 4, number of pipeline hold boundaries (index 0 = pc, STAGES-1 = ex_memwb)
  EXS, STAGES-1, index of the first boundary at or after EX (stages below EXS are upstream of EX)
  ADDR_W, 32, instruction address width
  DRAIN_CYC, 2, cycles allowed for EX/MEM/WB drain before an IRQ or halt redirect; legal range 1..15
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  single clock
  rst_n  in  1  asynchronous active-low reset
  mem_wb_wr_wait_req_i  in  1  memory write-back stall
  ex_multi_clock_wait_req_i  in  1  multi-cycle EX op busy
  ex_jump_cause_i  in  3  EX redirect cause
  ex_jump_from_addr_i / ex_jump_to_addr_i  in  ADDR_W  EX redirect source and target
  epc_i  in  ADDR_W  oldest not-yet-retired PC (resume address)
  irq_req_i  in  1  level interrupt request
  irq_vector_i  in  ADDR_W  interrupt handler address
  jtag_halt_req_i  in  1  level debug halt request
  hold_ctrl_o  out  2*STAGES  per-boundary hold code, boundary i at bits [2i+1:2i]
  jump_cause_o  out  3  redirect cause to PC unit
  jump_from_addr_o / jump_to_addr_o  out  ADDR_W  redirect addresses
  irq_ack_o  out  1  one-cycle pulse on IRQ redirect
  irq_epc_o  out  ADDR_W  captured resume PC, valid with irq_ack_o
  jtag_halted_o  out  1  core is halted

Function
REQ-003 Hold codes: no=2'b00, wait=2'b01, flush=2'b10. Jump causes: no=0, predict_yes_but_no=1, predict_no_but_yes=2, nocondition=3, irq=4, resume=5.
REQ-004 The FSM SHALL have the states IDLE, DRAIN, IRQ_JMP, HALTED and RESUME. The register kind (irq or halt) SHALL be latched on entry to DRAIN.
REQ-005 Priority (highest first) in every state: mem wait > multi-clock wait > FSM action > EX jump > none.
REQ-006 On mem wait, all boundaries SHALL be set to wait, the DRAIN counter SHALL freeze, and jump_* SHALL be set to no/zero.
REQ-007 On multi-clock wait, boundaries < EXS SHALL be set to wait, boundaries >= EXS SHALL be set to flush, and the counter SHALL freeze.
REQ-008 On an EX jump (cause 1..3) in IDLE, jump_* SHALL pass the EX values combinationally, boundary 0 SHALL be set to wait, boundaries 1..EXS-1 to flush, and boundaries >= EXS to no.
REQ-009 IDLE -> DRAIN when irq_req_i=1 or jtag_halt_req_i=1, no wait is active and there is no EX jump; irq wins when both are asserted. epc_i is captured on entry and the counter is loaded with DRAIN_CYC.
REQ-010 In DRAIN, the hold pattern SHALL equal the REQ-008 pattern with jump_* set to no. The counter SHALL decrement each unstalled cycle. At 0 the FSM SHALL move to IRQ_JMP (irq) or HALTED (halt).
REQ-011 An EX jump during DRAIN SHALL NOT be forwarded; the captured EPC SHALL be replaced with ex_jump_to_addr_i instead.
REQ-012 IRQ_JMP SHALL last exactly one cycle with cause=irq, to=irq_vector_i, from=captured EPC, irq_ack_o=1 and irq_epc_o=captured EPC, then return to IDLE.
REQ-013 In HALTED, jtag_halted_o=1, boundary 0 SHALL be set to wait and the others to no; the FSM SHALL move to RESUME when jtag_halt_req_i=0. irq_req_i SHALL be ignored while in HALTED.
REQ-014 RESUME SHALL last one cycle with cause=resume and to=from=captured EPC, then return to IDLE.
REQ-015 A halt request that arrives in a non-IDLE state SHALL be serviced only after the FSM returns to IDLE.
REQ-016 Outputs not driven by a rule SHALL be zero or no.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE, counter=0 and captured EPC=0, which gives all holds = no, jump_cause_o = no, addresses = 0, irq_ack_o = 0 and jtag_halted_o = 0. Reset SHALL abort any in-progress DRAIN, IRQ_JMP or HALTED state with no redirect.
REQ-018 Deassertion SHALL take effect at the next clk edge, and the first cycle after reset SHALL be IDLE.

Structure
REQ-019 Hold codes, jump cause codes, bus widths and FSM state encodings SHALL live in the shared define package.
REQ-020 One sub-module, hold_pattern_gen, SHALL be the purely combinational mapping from {mode: none, all_wait, multi, redirect, halted} to the 2*STAGES hold vector, parameterised by STAGES and EXS.

Verification
REQ-021 Directed scenarios:
  - mem wait together with a cause=3 jump (to 0x100) -> hold_ctrl_o=8'h55, jump_cause_o=0.
  - irq_req_i=1, epc_i=0x80, vector 0x400, DRAIN_CYC=2 -> hold 8'h29 for 2 cycles, then cause=4, to=0x400, from=0x80, irq_ack_o pulses once.
  - IRQ drain with a cause=2 jump to 0x200 in the first DRAIN cycle -> no forward, irq_epc_o=0x200.
  - jtag_halt_req_i held for 10 cycles -> jtag_halted_o=1 after drain; on release, one cycle with cause=5 and to=captured EPC.
  - irq and halt asserted together -> IRQ serviced first, halt follows after IDLE.
  - rst_n pulsed low mid-DRAIN -> all outputs zero asynchronously, no ack afterwards.
